// File: rtl/watchdog_supervisor_pkg.sv
// Shared types and widths for the watchdog supervisor.
//   wd_state_e  : 3-bit supervisor FSM state, encoding visible on the state output
//   TRIP_CNT_W  : width of the saturating trip counter
//   REARM_CNT_W : width of the automatic re-arm counter
package watchdog_supervisor_pkg;

   localparam int unsigned TRIP_CNT_W  = 8;
   localparam int unsigned REARM_CNT_W = 4;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StArmed   = 3'd1,
      StWarn    = 3'd2,
      StTripped = 3'd3,
      StHold    = 3'd4,
      StRearm   = 3'd5,
      StLockout = 3'd6
   } wd_state_e;

endpackage

// File: rtl/watchdog_supervisor_if.sv
// Signal bundle between the supervisor and its surroundings (clients, watchdog_timer, software).
//   master : drives arm/kick/client_mask/wd_warning/wd_triggered/ack_fault, observes outputs
//   slave  : the supervisor itself
interface watchdog_supervisor_if
   import watchdog_supervisor_pkg::*;
#(
   parameter int unsigned N_CLIENTS = 4
);
   logic                  arm;
   logic [N_CLIENTS-1:0]  kick;
   logic [N_CLIENTS-1:0]  client_mask;
   logic                  wd_warning;
   logic                  wd_triggered;
   logic                  ack_fault;
   logic                  wd_enable;
   logic                  wd_heartbeat;
   logic                  wd_force_reset;
   logic                  rf_mute;
   logic [2:0]            state;
   logic [N_CLIENTS-1:0]  missing;
   logic [TRIP_CNT_W-1:0] trip_count;

   modport master (
      output arm, kick, client_mask, wd_warning, wd_triggered, ack_fault,
      input  wd_enable, wd_heartbeat, wd_force_reset, rf_mute, state, missing, trip_count
   );

   modport slave (
      input  arm, kick, client_mask, wd_warning, wd_triggered, ack_fault,
      output wd_enable, wd_heartbeat, wd_force_reset, rf_mute, state, missing, trip_count
   );

endinterface

// File: rtl/wd_kick_collector.sv
// Collects per-client kicks over a window of WINDOW_CYCLES cycles.
//   en_i            : collection active this cycle (supervisor in ARMED/WARN, no higher-priority event)
//   clr_i           : clear kicked vector and window counter
//   kick_i, mask_i  : per-client check-in pulses and required-client mask
//   heartbeat_req_o : every required client has checked in this window (combinational)
//   expire_o        : window closed this cycle without completion (combinational)
//   missing_o       : required clients absent, valid when expire_o is high
module wd_kick_collector
   import watchdog_supervisor_pkg::*;
#(
   parameter int unsigned N_CLIENTS     = 4,
   parameter int unsigned WINDOW_CYCLES = 1000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en_i,
   input  logic                 clr_i,
   input  logic [N_CLIENTS-1:0] kick_i,
   input  logic [N_CLIENTS-1:0] mask_i,
   output logic                 heartbeat_req_o,
   output logic                 expire_o,
   output logic [N_CLIENTS-1:0] missing_o
);
   localparam int unsigned     CntW    = $clog2(WINDOW_CYCLES);
   localparam logic [CntW-1:0] CntLast = CntW'(WINDOW_CYCLES - 1);

   logic [N_CLIENTS-1:0] kicked_q, kicked_d, kicked_next;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic                 complete, at_last;

   always_comb begin
      // Kicks in the closing cycle still count toward this window.
      kicked_next     = kicked_q | (kick_i & mask_i);
      complete        = (mask_i != '0) && ((kicked_next & mask_i) == mask_i);
      at_last         = (cnt_q == CntLast);
      heartbeat_req_o = en_i && complete;
      expire_o        = en_i && at_last && !complete;
      missing_o       = mask_i & ~kicked_next;

      kicked_d = kicked_q;
      cnt_d    = cnt_q;
      if (clr_i) begin
         kicked_d = '0;
         cnt_d    = '0;
      end else if (en_i) begin
         if (complete || at_last) begin
            kicked_d = '0;
            cnt_d    = '0;
         end else begin
            kicked_d = kicked_next;
            cnt_d    = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kicked_q <= '0;
         cnt_q    <= '0;
      end else begin
         kicked_q <= kicked_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/watchdog_supervisor.sv
// Watchdog supervisor: turns client kicks into a single heartbeat for watchdog_timer, and on a
// trip mutes RF, pulses force_reset, holds off, auto re-arms a bounded number of times, then
// locks out until software acknowledges.
//   clk, rst : clock, asynchronous active-high reset
//   bus_io   : slave side of watchdog_supervisor_if (all outputs registered)
module watchdog_supervisor
   import watchdog_supervisor_pkg::*;
#(
   parameter int unsigned N_CLIENTS      = 4,
   parameter int unsigned WINDOW_CYCLES  = 1000,
   parameter int unsigned HOLD_CYCLES    = 256,
   parameter int unsigned MAX_AUTO_REARM = 3
) (
   input logic                  clk,
   input logic                  rst,
   watchdog_supervisor_if.slave bus_io
);
   localparam int unsigned            HoldW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HoldW-1:0]       HoldLast = HoldW'(HOLD_CYCLES - 1);
   localparam logic [REARM_CNT_W-1:0] RearmMax = REARM_CNT_W'(MAX_AUTO_REARM);

   wd_state_e              state_q, state_d;
   logic [HoldW-1:0]       hold_q, hold_d;
   logic [REARM_CNT_W-1:0] rearm_q, rearm_d;
   logic [TRIP_CNT_W-1:0]  trip_q, trip_d;
   logic [N_CLIENTS-1:0]   missing_q, missing_d;
   logic                   enable_q, enable_d, mute_q, mute_d;
   logic                   hb_q, hb_d, force_q, force_d;
   logic                   collect_en, hb_req, expire;
   logic [N_CLIENTS-1:0]   coll_missing;

   wd_kick_collector #(
      .N_CLIENTS    (N_CLIENTS),
      .WINDOW_CYCLES(WINDOW_CYCLES)
   ) u_collector (
      .clk            (clk),
      .rst            (rst),
      .en_i           (collect_en),
      .clr_i          (!collect_en),
      .kick_i         (bus_io.kick),
      .mask_i         (bus_io.client_mask),
      .heartbeat_req_o(hb_req),
      .expire_o       (expire),
      .missing_o      (coll_missing)
   );

   // State register plus the registered outputs and counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         hold_q    <= '0;
         rearm_q   <= '0;
         trip_q    <= '0;
         missing_q <= '0;
         enable_q  <= 1'b0;
         mute_q    <= 1'b1;
         hb_q      <= 1'b0;
         force_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         rearm_q   <= rearm_d;
         trip_q    <= trip_d;
         missing_q <= missing_d;
         enable_q  <= enable_d;
         mute_q    <= mute_d;
         hb_q      <= hb_d;
         force_q   <= force_d;
      end
   end

   // Next state. Kick collection only runs when no higher-priority event claims the cycle.
   always_comb begin
      state_d    = state_q;
      collect_en = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus_io.arm) state_d = StArmed;
         end
         StArmed, StWarn: begin
            if (!bus_io.arm) begin
               state_d = StIdle;
            end else if (bus_io.wd_triggered) begin
               state_d = StTripped;
            end else begin
               collect_en = 1'b1;
               state_d    = bus_io.wd_warning ? StWarn : StArmed;
            end
         end
         StTripped: state_d = bus_io.arm ? StHold : StIdle;
         StHold: begin
            if (!bus_io.arm) begin
               state_d = StIdle;
            end else if (hold_q == HoldLast) begin
               state_d = (rearm_q < RearmMax) ? StRearm : StLockout;
            end
         end
         StRearm: state_d = bus_io.arm ? StArmed : StIdle;
         StLockout: begin
            if (bus_io.ack_fault) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Next values of the registered outputs, decoded from the upcoming state.
   always_comb begin
      hold_d  = (state_q == StHold) ? hold_q + HoldW'(1) : '0;

      rearm_d = rearm_q;
      if (state_d == StIdle) begin
         rearm_d = '0;
      end else if (state_q == StRearm) begin
         rearm_d = rearm_q + REARM_CNT_W'(1);
      end

      trip_d = trip_q;
      if ((state_q == StArmed || state_q == StWarn) && state_d == StTripped && trip_q != '1) begin
         trip_d = trip_q + TRIP_CNT_W'(1);
      end

      missing_d = expire ? coll_missing : missing_q;
      hb_d      = hb_req;
      enable_d  = (state_d == StArmed) || (state_d == StWarn) || (state_d == StRearm);
      mute_d    = !((state_d == StArmed) || (state_d == StWarn));
      force_d   = (state_d == StTripped);
   end

   assign bus_io.state          = state_q;
   assign bus_io.wd_enable      = enable_q;
   assign bus_io.rf_mute        = mute_q;
   assign bus_io.wd_heartbeat   = hb_q;
   assign bus_io.wd_force_reset = force_q;
   assign bus_io.missing        = missing_q;
   assign bus_io.trip_count     = trip_q;

endmodule

// File: tb/tb_watchdog_supervisor.sv
// Directed bench for watchdog_supervisor: a cycle-level reference model checked on every
// negedge, plus literal expectations at the key points of each scenario.
module tb_watchdog_supervisor;

   localparam int Window = 1000;
   localparam int Hold   = 256;
   localparam int MaxRe  = 3;

   localparam int MIdle = 0, MArmed = 1, MWarn = 2, MTrip = 3, MHold = 4, MRearm = 5, MLock = 6;

   logic clk = 1'b0;
   logic rst;

   watchdog_supervisor_if #(.N_CLIENTS(4)) bus_if ();

   watchdog_supervisor #(
      .N_CLIENTS     (4),
      .WINDOW_CYCLES (Window),
      .HOLD_CYCLES   (Hold),
      .MAX_AUTO_REARM(MaxRe)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .bus_io(bus_if)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_err  = 0;
   bit chk_en = 1'b0;
   int hb_cnt = 0;
   int hb_base;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference model: tracks the mode, the clients seen in the current window, the window age,
   // remaining hold-off cycles and the counters; updated from inputs sampled at each edge.
   int       m_mode = MIdle;
   bit [3:0] m_seen = '0;
   int       m_age = 0, m_hold = 0, m_rearms = 0, m_trips = 0;
   bit [3:0] m_missing = '0;
   bit       m_hb = 1'b0;
   bit [3:0] m_now;
   int       m_nxt;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode = MIdle; m_seen = '0; m_age = 0; m_hold = 0;
         m_rearms = 0; m_trips = 0; m_missing = '0; m_hb = 1'b0;
      end else begin
         m_hb  = 1'b0;
         m_nxt = m_mode;
         if (m_mode == MLock) begin
            if (bus_if.ack_fault) begin m_nxt = MIdle; m_rearms = 0; end
         end else if (!bus_if.arm) begin
            m_nxt = MIdle; m_rearms = 0;
         end else if (m_mode == MIdle) begin
            m_nxt = MArmed; m_seen = '0; m_age = 0;
         end else if (m_mode == MArmed || m_mode == MWarn) begin
            if (bus_if.wd_triggered) begin
               m_nxt = MTrip;
               if (m_trips < 255) m_trips++;
            end else begin
               m_nxt = bus_if.wd_warning ? MWarn : MArmed;
               m_now = m_seen | (bus_if.kick & bus_if.client_mask);
               if (bus_if.client_mask != 0 && (m_now & bus_if.client_mask) == bus_if.client_mask)
               begin
                  m_hb = 1'b1; m_seen = '0; m_age = 0;
               end else if (m_age == Window - 1) begin
                  m_missing = bus_if.client_mask & ~m_now; m_seen = '0; m_age = 0;
               end else begin
                  m_seen = m_now; m_age++;
               end
            end
         end else if (m_mode == MTrip) begin
            m_nxt = MHold; m_hold = Hold;
         end else if (m_mode == MHold) begin
            m_hold--;
            if (m_hold == 0) m_nxt = (m_rearms < MaxRe) ? MRearm : MLock;
         end else if (m_mode == MRearm) begin
            m_rearms++; m_seen = '0; m_age = 0; m_nxt = MArmed;
         end
         m_mode = m_nxt;
      end
   end

   always @(negedge clk) begin
      if (bus_if.wd_heartbeat) hb_cnt++;
      if (chk_en) begin
         chk("model.state", 32'(bus_if.state), 32'(m_mode));
         chk("model.wd_enable", 32'(bus_if.wd_enable),
             32'(m_mode == MArmed || m_mode == MWarn || m_mode == MRearm));
         chk("model.rf_mute", 32'(bus_if.rf_mute), 32'(!(m_mode == MArmed || m_mode == MWarn)));
         chk("model.wd_force_reset", 32'(bus_if.wd_force_reset), 32'(m_mode == MTrip));
         chk("model.wd_heartbeat", 32'(bus_if.wd_heartbeat), 32'(m_hb));
         chk("model.missing", 32'(bus_if.missing), 32'(m_missing));
         chk("model.trip_count", 32'(bus_if.trip_count), 32'(m_trips));
      end
   end

   initial begin
      rst = 1'b1;
      bus_if.arm = 1'b0; bus_if.kick = '0; bus_if.client_mask = '0;
      bus_if.wd_warning = 1'b0; bus_if.wd_triggered = 1'b0; bus_if.ack_fault = 1'b0;
      step(1);
      chk("rst.state", 32'(bus_if.state), 0);
      chk("rst.rf_mute", 32'(bus_if.rf_mute), 1);
      chk("rst.wd_enable", 32'(bus_if.wd_enable), 0);
      chk("rst.trip_count", 32'(bus_if.trip_count), 0);
      chk("rst.missing", 32'(bus_if.missing), 0);
      rst = 1'b0;
      chk_en = 1'b1;

      // Arm and kick every client once: heartbeat one cycle after the last kick.
      bus_if.client_mask = 4'hF; bus_if.arm = 1'b1;
      step(1);
      chk("t1.state", 32'(bus_if.state), 1);
      chk("t1.wd_enable", 32'(bus_if.wd_enable), 1);
      chk("t1.rf_mute", 32'(bus_if.rf_mute), 0);
      for (int i = 0; i < 4; i++) begin
         bus_if.kick = 4'(1 << i);
         step(1);
         bus_if.kick = '0;
         if (i < 3) begin
            chk("t1.hb_early", 32'(bus_if.wd_heartbeat), 0);
            step(2);
         end
      end
      chk("t1.hb_after_last", 32'(bus_if.wd_heartbeat), 1);
      step(1);
      chk("t1.hb_one_cycle", 32'(bus_if.wd_heartbeat), 0);

      // Client 2 never kicks; client 3 is masked out.
      hb_base = hb_cnt;
      bus_if.client_mask = 4'b0111;
      bus_if.kick = 4'b0001; step(1);
      bus_if.kick = 4'b1000; step(1);
      bus_if.kick = 4'b0010; step(1);
      bus_if.kick = 4'b1000; step(1);
      bus_if.kick = '0;
      step(1000);
      chk("t2.missing", 32'(bus_if.missing), 32'h4);
      chk("t2.no_hb", 32'(hb_cnt - hb_base), 0);

      // Resync the window, then land all kicks exactly in the expiry cycle.
      bus_if.client_mask = 4'hF; bus_if.kick = 4'hF;
      step(1);
      bus_if.kick = '0;
      step(Window - 1);
      bus_if.kick = 4'hF;
      step(1);
      bus_if.kick = '0;
      chk("t3.hb_on_expiry", 32'(bus_if.wd_heartbeat), 1);
      chk("t3.missing_kept", 32'(bus_if.missing), 32'h4);

      bus_if.wd_warning = 1'b1; step(1);
      chk("t3.warn", 32'(bus_if.state), 2);
      bus_if.wd_warning = 1'b0; step(1);
      chk("t3.unwarn", 32'(bus_if.state), 1);

      // Warning, trip, hold-off, re-arm.
      bus_if.wd_warning = 1'b1; step(1);
      chk("t4.warn", 32'(bus_if.state), 2);
      bus_if.wd_triggered = 1'b1; step(1);
      bus_if.wd_triggered = 1'b0; bus_if.wd_warning = 1'b0;
      chk("t4.tripped", 32'(bus_if.state), 3);
      chk("t4.force", 32'(bus_if.wd_force_reset), 1);
      chk("t4.mute", 32'(bus_if.rf_mute), 1);
      chk("t4.enable", 32'(bus_if.wd_enable), 0);
      chk("t4.trips", 32'(bus_if.trip_count), 1);
      step(1);
      chk("t4.hold", 32'(bus_if.state), 4);
      chk("t4.force_off", 32'(bus_if.wd_force_reset), 0);
      step(Hold - 1);
      chk("t4.hold_last", 32'(bus_if.state), 4);
      step(1);
      chk("t4.rearm", 32'(bus_if.state), 5);
      step(1);
      chk("t4.rearmed", 32'(bus_if.state), 1);
      chk("t4.unmute", 32'(bus_if.rf_mute), 0);

      // Trips 2..4: the fourth exhausts the re-arm budget.
      for (int k = 2; k <= 4; k++) begin
         bus_if.wd_triggered = 1'b1; step(1);
         bus_if.wd_triggered = 1'b0;
         step(Hold + 1);
         if (k < 4) begin
            chk("t5.rearm", 32'(bus_if.state), 5);
            step(1);
         end else begin
            chk("t5.lockout", 32'(bus_if.state), 6);
         end
      end
      chk("t5.trips", 32'(bus_if.trip_count), 4);
      bus_if.arm = 1'b0; step(3);
      chk("t5.arm_low_ignored", 32'(bus_if.state), 6);
      bus_if.arm = 1'b1; step(2);
      chk("t5.arm_high_ignored", 32'(bus_if.state), 6);
      chk("t5.mute", 32'(bus_if.rf_mute), 1);
      bus_if.ack_fault = 1'b1; step(1);
      bus_if.ack_fault = 1'b0;
      chk("t5.ack_idle", 32'(bus_if.state), 0);
      chk("t5.trips_kept", 32'(bus_if.trip_count), 4);
      step(1);
      chk("t5.rearmed", 32'(bus_if.state), 1);

      // Disarm in the middle of a hold-off, then reset while armed.
      bus_if.wd_triggered = 1'b1; step(1);
      bus_if.wd_triggered = 1'b0;
      step(100);
      chk("t6.in_hold", 32'(bus_if.state), 4);
      bus_if.arm = 1'b0; step(1);
      chk("t6.idle", 32'(bus_if.state), 0);
      chk("t6.enable", 32'(bus_if.wd_enable), 0);
      chk("t6.mute", 32'(bus_if.rf_mute), 1);
      bus_if.arm = 1'b1; step(3);
      chk("t6.armed", 32'(bus_if.state), 1);
      rst = 1'b1;
      #1;
      chk("t6.rst_state", 32'(bus_if.state), 0);
      chk("t6.rst_mute", 32'(bus_if.rf_mute), 1);
      chk("t6.rst_enable", 32'(bus_if.wd_enable), 0);
      chk("t6.rst_trips", 32'(bus_if.trip_count), 0);
      chk("t6.rst_missing", 32'(bus_if.missing), 0);
      step(2);
      rst = 1'b0;
      step(3);
      chk("t6.after_rst", 32'(bus_if.state), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/watchdog_supervisor.md
Name: watchdog_supervisor

Overview:
Sequences the watchdog_timer on the AM radio FPGA. Collects periodic kicks from N client blocks (host link, DDS, audio path, controller) and issues a single heartbeat only when every enabled client has checked in within a window. On a watchdog trip it mutes RF, pulses force_reset, holds off, then auto re-arms a bounded number of times before locking out until software acknowledges.

Parameters:
N_CLIENTS, 4, number of kick requesters
WINDOW_CYCLES, 1000, kick collection window length in clk cycles (>=2)
HOLD_CYCLES, 256, post-trip mute hold-off in clk cycles (>=1)
MAX_AUTO_REARM, 3, automatic re-arms allowed before LOCKOUT (1..15)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
arm  in  1  level; 1 = supervise, 0 = drop to IDLE
kick  in  N_CLIENTS  per-client single-cycle check-in pulse
client_mask  in  N_CLIENTS  1 = client required for heartbeat
wd_warning  in  1  from watchdog_timer
wd_triggered  in  1  from watchdog_timer
ack_fault  in  1  software pulse, leaves LOCKOUT
wd_enable  out  1  to watchdog_timer enable
wd_heartbeat  out  1  single-cycle pulse to watchdog_timer
wd_force_reset  out  1  single-cycle pulse to watchdog_timer
rf_mute  out  1  1 = RF output muted
state  out  3  current FSM state
missing  out  N_CLIENTS  clients absent at last failed window close
trip_count  out  8  saturating trip counter

Behaviour:
- Reset (async): state=IDLE, rf_mute=1, all other outputs 0; kicked vector, window counter and rearm counter = 0.
- All outputs registered. State encoding: IDLE=0, ARMED=1, WARN=2, TRIPPED=3, HOLD=4, REARM=5, LOCKOUT=6.
- Priority per cycle: arm=0 (except in LOCKOUT) > wd_triggered > wd_warning > kick/window logic.
- IDLE: wd_enable=0, rf_mute=1. arm=1 -> REARM path skipped; go directly to ARMED next cycle with wd_enable=1, rf_mute=0, window cleared, rearm counter not incremented.
- ARMED/WARN kick collection:
  - kicked_next = kicked | (kick & client_mask).
  - complete = client_mask!=0 and (kicked_next & client_mask)==client_mask. On complete, wd_heartbeat=1 in the following cycle for exactly 1 cycle, kicked and window counter cleared.
  - Window counter increments each cycle. When it reaches WINDOW_CYCLES-1 without complete: missing <= client_mask & ~kicked_next; kicked and counter cleared; no heartbeat. A kick arriving in the expiry cycle counts toward that window.
  - complete takes precedence over expiry in the same cycle; missing unchanged on complete.
  - client_mask==0: never heartbeats (configuration fault, watchdog will expire).
- ARMED -> WARN when wd_warning=1; WARN -> ARMED when wd_warning=0.
- ARMED/WARN with wd_triggered=1 -> TRIPPED: rf_mute=1 from next cycle, trip_count += 1 (saturates at 255).
- TRIPPED: 1 cycle, wd_force_reset=1, wd_enable=0 -> HOLD.
- HOLD: rf_mute=1, wd_enable=0 for exactly HOLD_CYCLES cycles. Exit: rearm counter < MAX_AUTO_REARM -> REARM, else -> LOCKOUT.
- REARM: 1 cycle. rearm counter += 1, kicked and window cleared, wd_enable=1 -> ARMED with rf_mute=0.
- LOCKOUT: rf_mute=1, wd_enable=0; arm ignored; ack_fault=1 -> IDLE, rearm counter cleared.
- arm=0 in any non-LOCKOUT state: IDLE next cycle, rf_mute=1, wd_enable=0, rearm counter cleared. A hold-off in progress is abandoned.
- trip_count and missing clear only on rst.

Decomposition:
- Package watchdog_supervisor_pkg: state enum (3-bit), TRIP_CNT_W=8, REARM_CNT_W=4.
- Sub-module wd_kick_collector holds the kicked vector and window counter. It has outputs heartbeat_req and expire/missing, plus a clear input. The FSM stays in the top module.

Test Plan:
- rst, mask=4'b1111, arm=1, kick each client once within 100 cycles -> one wd_heartbeat pulse 1 cycle after the last kick; state=1, rf_mute=0.
- mask=4'b0111, kick only clients 0 and 1, wait 1000 cycles -> no heartbeat, missing=4'b0100. Client 3 kicks are ignored throughout.
- All 4 kicks in the same cycle as window expiry -> heartbeat issued, missing unchanged.
- wd_warning=1 then wd_triggered=1 -> state 1->2->3; wd_force_reset high 1 cycle; rf_mute=1; trip_count=1; 256 cycles in HOLD; REARM then ARMED with rf_mute=0.
- Four successive trips with MAX_AUTO_REARM=3 -> fourth HOLD exits to LOCKOUT (6). arm toggling has no effect; ack_fault -> IDLE; trip_count=4.
- arm=0 mid-HOLD at cycle 100 -> IDLE next cycle; rst asserted mid-ARMED -> all outputs at reset values immediately, rf_mute=1.
